waveform_to_pipe: RTL and testbench

//  Records a 32-bit simulation trace (f_muscle_len, f_total_force, ...) into block RAM, one entry per sample strobe.

---
 rtl/waveform_to_pipe.sv | 119 +++++++++++
 tb/tb_waveform_to_pipe.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/waveform_to_pipe.sv
// Captures a 32-bit trace into block RAM after arm, then streams it to the host
// as 16-bit pipe words (low half first), one word per pipe_read.
module waveform_to_pipe #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  arm,
    input  logic [DEPTH_LOG2:0]   num_samples,
    input  logic                  sample_valid,
    input  logic [31:0]           sample_in,
    input  logic                  pipe_read,
    output logic [15:0]           pipe_data,
    output logic                  pipe_ready,
    output logic                  busy,
    output logic                  done,
    output logic [DEPTH_LOG2:0]   samples_recorded,
    output logic                  overrun
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DEPTH_N = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   ONE_P   = 1;
    localparam logic [DEPTH_LOG2+1:0] ONE_W   = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECORD  = 2'd1,
        READOUT = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DEPTH_LOG2:0]     n_q, n_d;
    logic [DEPTH_LOG2:0]     wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2+1:0]   rd_word_q, rd_word_d;
    logic                    overrun_q, overrun_d;
    logic                    vld_q, vld_d;
    logic                    we, re;
    logic [DEPTH_LOG2+1:0]   last_word;
    logic [31:0]             ram_q;
    logic [31:0]             mem [DEPTH];

    assign last_word = {n_q, 1'b0} - ONE_W;

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        wr_ptr_d  = wr_ptr_q;
        rd_word_d = rd_word_q;
        overrun_d = overrun_q;
        vld_d     = vld_q;
        we        = 1'b0;
        re        = 1'b0;
        if (arm) begin
            state_d   = RECORD;
            n_d       = (num_samples == '0 || num_samples > DEPTH_N) ? DEPTH_N : num_samples;
            wr_ptr_d  = '0;
            rd_word_d = '0;
            overrun_d = 1'b0;
            vld_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pipe_read) overrun_d = 1'b1;
                end
                RECORD: begin
                    if (pipe_read) overrun_d = 1'b1;
                    if (sample_valid) begin
                        we       = 1'b1;
                        wr_ptr_d = wr_ptr_q + ONE_P;
                        if (wr_ptr_d == n_q) state_d = READOUT;
                    end
                end
                READOUT: begin
                    // First READOUT cycle only prefetches word 0; vld_q then opens the pipe.
                    re    = 1'b1;
                    vld_d = 1'b1;
                    if (vld_q && pipe_read) begin
                        if (rd_word_q == last_word) state_d = IDLE;
                        else                        rd_word_d = rd_word_q + ONE_W;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            n_q       <= DEPTH_N;
            wr_ptr_q  <= '0;
            rd_word_q <= '0;
            overrun_q <= 1'b0;
            vld_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_word_q <= rd_word_d;
            overrun_q <= overrun_d;
            vld_q     <= vld_d;
        end
    end

    // Read address follows the next word pointer so the following word is ready one clk later.
    always_ff @(posedge clk) begin
        if (we && !reset) mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= sample_in;
        if (re && !reset) ram_q <= mem[rd_word_d[DEPTH_LOG2:1]];
    end

    assign busy             = (state_q == RECORD);
    assign done             = (state_q == READOUT);
    assign pipe_ready       = done && vld_q;
    assign pipe_data        = vld_q ? (rd_word_q[0] ? ram_q[31:16] : ram_q[15:0]) : 16'h0000;
    assign samples_recorded = wr_ptr_q;
    assign overrun          = overrun_q;

endmodule

// File: tb/tb_waveform_to_pipe.sv
// Scoreboard bench for waveform_to_pipe with an 8-deep buffer: stimulus pushes
// expected pipe words, a monitor pops them whenever a read is accepted.
module tb_waveform_to_pipe;

    localparam int DL2 = 3;

    logic              clk = 1'b0;
    logic              reset, arm, sample_valid, pipe_read;
    logic [DL2:0]      num_samples;
    logic [31:0]       sample_in;
    logic [15:0]       pipe_data;
    logic              pipe_ready, busy, done, overrun;
    logic [DL2:0]      samples_recorded;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    waveform_to_pipe #(.DEPTH_LOG2(DL2)) dut (
        .clk(clk), .reset(reset), .arm(arm), .num_samples(num_samples),
        .sample_valid(sample_valid), .sample_in(sample_in), .pipe_read(pipe_read),
        .pipe_data(pipe_data), .pipe_ready(pipe_ready), .busy(busy), .done(done),
        .samples_recorded(samples_recorded), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input logic [DL2:0] n);
        arm = 1'b1;
        num_samples = n;
        tick();
        arm = 1'b0;
    endtask

    task automatic send(input logic [31:0] v);
        sample_valid = 1'b1;
        sample_in = v;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic expect_sample(input logic [31:0] v);
        exp_q.push_back(v[15:0]);
        exp_q.push_back(v[31:16]);
    endtask

    task automatic wait_ready(input string name);
        int k = 0;
        while (!pipe_ready && k < 10) begin
            tick();
            k++;
        end
        chk(name, {31'd0, pipe_ready}, 32'd1);
    endtask

    task automatic drain(input int count, input bit gaps);
        for (int i = 0; i < count; i++) begin
            pipe_read = 1'b1;
            tick();
            if (gaps) begin
                pipe_read = 1'b0;
                tick();
            end
        end
        pipe_read = 1'b0;
    endtask

    always @(negedge clk) begin
        if (pipe_ready && pipe_read) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pipe_word unexpected read got %h expected none", pipe_data);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (pipe_data !== e) begin
                    errors++;
                    $display("FAIL pipe_word got %h expected %h", pipe_data, e);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; arm = 1'b0; sample_valid = 1'b0; pipe_read = 1'b0;
        num_samples = '0; sample_in = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ready", {31'd0, pipe_ready}, 32'd0);
        chk("rst_data", {16'd0, pipe_data}, 32'd0);
        chk("rst_count", {28'd0, samples_recorded}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);

        // N=4 basic capture and drain with gaps
        do_arm(4'd4);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 4; i++) send(32'h3F80_0000 + i);
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_count", {28'd0, samples_recorded}, 32'd4);
        chk("t1_busy_off", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 4; i++) expect_sample(32'h3F80_0000 + i);
        wait_ready("t1_ready");
        chk("t1_word0", {16'd0, pipe_data}, 32'h0000);
        drain(8, 1'b1);
        chk("t1_queue", exp_q.size(), 32'd0);
        chk("t1_done_off", {31'd0, done}, 32'd0);
        chk("t1_ready_off", {31'd0, pipe_ready}, 32'd0);
        chk("t1_hold", {16'd0, pipe_data}, 32'h3F80);
        chk("t1_overrun", {31'd0, overrun}, 32'd0);

        // 9th read past the end
        pipe_read = 1'b1; tick(); pipe_read = 1'b0;
        chk("t4_over_end", {31'd0, overrun}, 32'd1);
        chk("t4_hold_end", {16'd0, pipe_data}, 32'h3F80);

        // num_samples=0 means full depth; drain with pipe_read held high
        do_arm(4'd0);
        chk("t2_over_clr", {31'd0, overrun}, 32'd0);
        for (int i = 0; i < 7; i++) send(32'hA000_0010 * (i + 1) + i);
        chk("t2_busy7", {31'd0, busy}, 32'd1);
        send(32'hDEAD_BEEF);
        chk("t2_count", {28'd0, samples_recorded}, 32'd8);
        chk("t2_done", {31'd0, done}, 32'd1);
        for (int i = 0; i < 7; i++) expect_sample(32'hA000_0010 * (i + 1) + i);
        expect_sample(32'hDEAD_BEEF);
        wait_ready("t2_ready");
        drain(16, 1'b0);
        chk("t3_queue", exp_q.size(), 32'd0);
        chk("t3_done_off", {31'd0, done}, 32'd0);
        chk("t3_hold", {16'd0, pipe_data}, 32'hDEAD);
        chk("t3_overrun", {31'd0, overrun}, 32'd0);

        // pipe_read during RECORD
        do_arm(4'd4);
        send(32'h1111_2222);
        pipe_read = 1'b1; tick(); pipe_read = 1'b0;
        chk("t4_over_rec", {31'd0, overrun}, 32'd1);
        chk("t4_data_rec", {16'd0, pipe_data}, 32'h0000);
        chk("t4_busy_rec", {31'd0, busy}, 32'd1);

        // arm coincident with the 4th sample: sample dropped, count restarts
        do_arm(4'd5);
        chk("t5_over_clr", {31'd0, overrun}, 32'd0);
        for (int i = 0; i < 3; i++) send(32'h5500_0000 + i);
        chk("t5_count3", {28'd0, samples_recorded}, 32'd3);
        arm = 1'b1; num_samples = 4'd5; sample_valid = 1'b1; sample_in = 32'hBAD0_BAD0;
        tick();
        arm = 1'b0; sample_valid = 1'b0;
        chk("t5_count0", {28'd0, samples_recorded}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 5; i++) send(32'h7700_0100 + 32'h0001_0001 * i);
        chk("t5_count5", {28'd0, samples_recorded}, 32'd5);
        for (int i = 0; i < 5; i++) expect_sample(32'h7700_0100 + 32'h0001_0001 * i);
        wait_ready("t5_ready");
        drain(10, 1'b1);
        chk("t5_queue", exp_q.size(), 32'd0);

        // reset mid-READOUT after 3 reads
        do_arm(4'd4);
        for (int i = 0; i < 4; i++) send(32'hC0DE_0000 + i);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'hC0DE);
        exp_q.push_back(16'h0001);
        wait_ready("t6_ready");
        drain(3, 1'b1);
        chk("t6_done_pre", {31'd0, done}, 32'd1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("t6_ready", {31'd0, pipe_ready}, 32'd0);
        chk("t6_done", {31'd0, done}, 32'd0);
        chk("t6_data", {16'd0, pipe_data}, 32'h0000);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_count", {28'd0, samples_recorded}, 32'd0);
        chk("t6_queue", exp_q.size(), 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
